stream_byte_packer: RTL and testbench
=====================================

# stream_byte_packer

Downstream neighbour of the single-stage 8-bit valid/ready pipeline register. Consumes its byte stream and packs `NBYTES` consecutive bytes into one wide word on a registered valid/ready output. A flush request emits a partially filled word with its byte count. No combinational path exists from `out_ready` to `in_ready`.

## Interface
- `NBYTES`, default 4: bytes per output word; legal range 2..8.
- `CW`, default `$clog2(NBYTES+1)`: width of the byte count; derived, do not override.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: packer accepts a byte this cycle.
- `in_data` in 8: upstream byte.
- `flush` in 1: single-cycle request to emit the current partial word.
- `out_valid` out 1: output word valid (registered).
- `out_ready` in 1: downstream accepts the word.
- `out_data` out 8*NBYTES: packed word; unfilled lanes are zero.
- `out_bytes` out CW: number of valid bytes in `out_data` (1..NBYTES).

## Operation
**Internal state**
- Accumulator `acc[8*NBYTES]`.
- Lane counter `cnt` (0..NBYTES-1).
- Output register: `out_data`, `out_bytes`, `out_valid`.
- `flush_pend` flag.

**Input acceptance**
- `in_ready = !flush_pend && (cnt != NBYTES-1 || !out_valid)`.
- An accepted byte (`in_valid && in_ready`) is written to lane `cnt`.
- Lane placement is set by the byte-order macro (see Configuration).

**Word completion**
- Completion occurs when the byte is accepted with `cnt == NBYTES-1`.
- The full word (acc plus the new byte) loads the output register: `out_bytes = NBYTES`, `out_valid = 1`.
- `cnt` returns to 0 and `acc` clears to 0.

**Output drain**
- `out_valid && out_ready` clears `out_valid` at the edge.
- `out_data` and `out_bytes` hold their last value.
- A new word can load only when `out_valid == 0` at the start of the cycle.
- Loading never overwrites an undrained word.

**Flush**
- `flush == 1` sets `flush_pend`, unless the same edge completes a full word; in that case the flush is absorbed.
- A byte accepted on the flush edge is included before the flush takes effect.
- `flush_pend && !out_valid` at an edge executes the flush:
  - If `cnt > 0`: load `acc` into the output register, set `out_bytes = cnt`, `out_valid = 1`, `cnt = 0`, `acc = 0`.
  - If `cnt == 0`: no output.
  - In both cases `flush_pend` clears.
- While `flush_pend` is set, `in_ready = 0`.
- `flush` asserted while `flush_pend` is already set has no additional effect.

**Reset**
- `out_valid = 0`, `out_data = 0`, `out_bytes = 0`, `cnt = 0`, `acc = 0`, `flush_pend = 0`.
- `in_ready` therefore reads 1.
- Reset mid-word discards the partial bytes.
- Reset with `out_valid` high drops the word; no handshake completes.

## Timing
- Latency: the word is visible with `out_valid = 1` in the cycle after the edge that accepts its last byte.
- Flush latency: the partial word appears one cycle after the edge where `flush_pend` is set and the output slot is empty.
- Throughput: one byte per cycle sustained, provided downstream drains each word within `NBYTES-1` cycles.
  - If it does not, `in_ready` drops only at `cnt == NBYTES-1`.
- `in_ready` depends only on registered state (`cnt`, `out_valid`, `flush_pend`).

## Configuration
- `PACKER_BIG_ENDIAN_EN` defined: the first accepted byte of a word lands in the most significant lane `[8*NBYTES-1 -: 8]`, with later bytes filling downward. A partial word is left-aligned in `out_data`.
- `PACKER_BIG_ENDIAN_EN` undefined (default): the first byte lands in `[7:0]`, with later bytes filling upward. A partial word is right-aligned.
- All other behaviour is identical in both builds.

## Test plan
1. **Reset values:** assert `reset` asynchronously mid-cycle → `out_valid = 0`, `out_data = 0`, `out_bytes = 0`, `in_ready = 1` immediately, before the next clock edge.
2. **Full word, little-endian:**
   - Stimulus: `NBYTES = 4`, bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `out_ready = 1`.
   - Required: one cycle after 0x44 is accepted, `out_data = 0x44332211`, `out_bytes = 4`, `out_valid` high for exactly one cycle.
   - Big-endian build, same stimulus: `out_data = 0x11223344`.
3. **Backpressure:**
   - Stimulus: `out_ready = 0`, stream 8 bytes 0x01..0x08.
   - Required: first word 0x04030201 held; bytes 0x05..0x07 accepted; `in_ready = 0` at `cnt = 3`.
   - Raise `out_ready` for one cycle → the first word drains, 0x08 is accepted on the next edge, and word 0x08070605 appears.
4. **Partial flush:** bytes 0xAA, 0xBB, then `flush` pulse → `out_data = 0x0000BBAA`, `out_bytes = 2`; `in_ready = 0` for exactly the cycle in which `flush_pend` is set.
5. **Flush edge cases:**
   - `flush` on the same edge as the 4th byte → exactly one word, `out_bytes = 4`, no extra output.
   - `flush` with `cnt = 0` → no output, and `flush_pend` clears after one cycle.
   - `flush` while `out_valid = 1` and `out_ready = 0` → the partial word is emitted only after the held word drains.
6. **Reset mid-word:** 3 bytes accepted, then `reset` pulse, then 4 bytes 0x01..0x04 → single word 0x04030201; the earlier bytes are never output.

Source files
------------

// File: rtl/stream_byte_packer.sv
// stream_byte_packer
//   Packs NBYTES consecutive bytes from an 8-bit valid/ready stream into one
//   wide word presented on a registered valid/ready output. A single-cycle
//   flush request emits a partially filled word together with its byte count.
//   in_ready is computed from registered state only, so there is no
//   combinational path from out_ready to in_ready.
//
//   Optional build macro: PACKER_BIG_ENDIAN_EN
//     defined   - first byte of a word lands in the top lane, partial words
//                 are left-aligned.
//     undefined - first byte lands in [7:0], partial words are right-aligned.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   upstream byte valid
//   in_ready   out  packer accepts a byte this cycle
//   in_data    in   upstream byte [7:0]
//   flush      in   single-cycle request to emit the current partial word
//   out_valid  out  packed word valid (registered)
//   out_ready  in   downstream accepts the word
//   out_data   out  packed word [8*NBYTES-1:0], unfilled lanes are zero
//   out_bytes  out  number of valid bytes in out_data [CW-1:0]

module stream_byte_packer #(
    parameter int NBYTES = 4,
    parameter int CW     = $clog2(NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic [CW-1:0]         out_bytes
);

    localparam logic [CW-1:0] LAST_LANE = CW'(NBYTES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(NBYTES);

    logic [8*NBYTES-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [8*NBYTES-1:0] out_data_q, out_data_d;
    logic [CW-1:0]       out_bytes_q, out_bytes_d;
    logic                out_valid_q, out_valid_d;
    logic                flush_pend_q, flush_pend_d;

    logic                accept;
    logic                complete;
    logic                flush_exec;
    logic [CW-1:0]       lane;
    logic [8*NBYTES-1:0] acc_ins;   // accumulator with the incoming byte merged in

    always_comb begin
        // The last lane can only be filled when the output slot is empty, so a
        // completed word always has somewhere to go.
        in_ready   = !flush_pend_q && (cnt_q != LAST_LANE || !out_valid_q);
        accept     = in_valid && in_ready;
        complete   = accept && (cnt_q == LAST_LANE);
        flush_exec = flush_pend_q && !out_valid_q;

`ifdef PACKER_BIG_ENDIAN_EN
        lane = LAST_LANE - cnt_q;
`else
        lane = cnt_q;
`endif

        acc_ins = acc_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (lane == CW'(i)) acc_ins[8*i +: 8] = in_data;
        end

        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        out_valid_d  = out_valid_q;
        flush_pend_d = flush_pend_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (complete) begin
            out_data_d  = acc_ins;
            out_bytes_d = FULL_CNT;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            acc_d       = '0;
        end else if (accept) begin
            acc_d = acc_ins;
            cnt_d = cnt_q + CW'(1);
        end

        // in_ready is low while flush_pend is set, so flush execution never
        // coincides with an accepted byte.
        if (flush_exec) begin
            flush_pend_d = 1'b0;
            if (cnt_q != '0) begin
                out_data_d  = acc_q;
                out_bytes_d = cnt_q;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
            end
        end else if (!flush_pend_q && flush && !complete) begin
            // A flush that lands on a word-completing edge has nothing left to emit.
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_bytes_q  <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer (NBYTES = 4). Expected words are
// written in little-endian form and byte-reversed for the big-endian build.

module tb_stream_byte_packer;

    localparam int NBYTES = 4;
    localparam int CW     = $clog2(NBYTES + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [8*NBYTES-1:0] out_data;
    logic [CW-1:0]       out_bytes;

    int n_checks = 0;
    int n_errors = 0;

    stream_byte_packer #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    function automatic logic [31:0] w(input logic [31:0] le);
`ifdef PACKER_BIG_ENDIAN_EN
        return {le[7:0], le[15:8], le[23:16], le[31:24]};
`else
        return le;
`endif
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_bytes", out_bytes, 0);
        chk("rst_in_ready",  in_ready, 1);

        // Full word, sustained input, downstream always ready
        out_ready = 1'b1;
        send(8'h11); chk("full_v0", out_valid, 0);
        send(8'h22); chk("full_v1", out_valid, 0);
        send(8'h33); chk("full_v2", out_valid, 0);
        send(8'h44);
        in_valid = 1'b0;
        chk("full_valid", out_valid, 1);
        chk("full_data",  out_data, w(32'h44332211));
        chk("full_bytes", out_bytes, 4);
        tick();
        chk("full_one_cycle", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("bp_w1_valid", out_valid, 1);
        chk("bp_w1_data",  out_data, w(32'h04030201));
        chk("bp_ready_cnt0", in_ready, 1);
        send(8'h05); send(8'h06); send(8'h07);
        chk("bp_ready_cnt3", in_ready, 0);
        send(8'h08);                         // refused: in_ready low
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data",  out_data, w(32'h04030201));
        chk("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();                              // drains first word, 0x08 still refused
        out_ready = 1'b0;
        chk("bp_drained",    out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        tick();                              // 0x08 accepted, word completes
        in_valid = 1'b0;
        chk("bp_w2_valid", out_valid, 1);
        chk("bp_w2_data",  out_data, w(32'h08070605));
        chk("bp_w2_bytes", out_bytes, 4);
        out_ready = 1'b1;
        tick();
        chk("bp_w2_drain", out_valid, 0);

        // Partial flush
        send(8'hAA); send(8'hBB);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("pf_pend_ready", in_ready, 0);
        chk("pf_pend_valid", out_valid, 0);
        tick();
        chk("pf_valid", out_valid, 1);
        chk("pf_data",  out_data, w(32'h0000BBAA));
        chk("pf_bytes", out_bytes, 2);
        chk("pf_ready", in_ready, 1);
        tick();
        chk("pf_drain", out_valid, 0);

        // Flush on the word-completing edge is absorbed
        send(8'h01); send(8'h02); send(8'h03);
        flush = 1'b1;
        send(8'h04);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fc_valid", out_valid, 1);
        chk("fc_bytes", out_bytes, 4);
        chk("fc_data",  out_data, w(32'h04030201));
        chk("fc_ready", in_ready, 1);
        tick();
        chk("fc_no_extra0", out_valid, 0);
        tick();
        chk("fc_no_extra1", out_valid, 0);
        chk("fc_ready2",    in_ready, 1);

        // Flush with an empty accumulator
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fe_pend_ready", in_ready, 0);
        tick();
        chk("fe_clear_ready", in_ready, 1);
        chk("fe_no_out",      out_valid, 0);
        tick();
        chk("fe_no_out2",     out_valid, 0);

        // Flush while a word is held
        out_ready = 1'b0;
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        send(8'h50);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("fh_held_valid", out_valid, 1);
        chk("fh_held_data",  out_data, w(32'h40302010));
        chk("fh_pend_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("fh_drained",    out_valid, 0);
        chk("fh_still_pend", in_ready, 0);
        tick();
        chk("fh_valid", out_valid, 1);
        chk("fh_data",  out_data, w(32'h00000050));
        chk("fh_bytes", out_bytes, 1);
        tick();
        chk("fh_drain", out_valid, 0);
        chk("fh_ready", in_ready, 1);

        // Asynchronous reset mid-cycle with a held word and a partial word
        out_ready = 1'b0;
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        send(8'hD1); send(8'hD2); send(8'hD3);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data",  out_data, 0);
        chk("ar_out_bytes", out_bytes, 0);
        chk("ar_in_ready",  in_ready, 1);
        tick();
        reset = 1'b0;

        // Partial bytes from before reset must not appear
        out_ready = 1'b1;
        send(8'h01); chk("rm_v0", out_valid, 0);
        send(8'h02); chk("rm_v1", out_valid, 0);
        send(8'h03); chk("rm_v2", out_valid, 0);
        send(8'h04);
        in_valid = 1'b0;
        chk("rm_valid", out_valid, 1);
        chk("rm_data",  out_data, w(32'h04030201));
        chk("rm_bytes", out_bytes, 4);
        tick();
        chk("rm_drain", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
